chunk_password_extractor: RTL

CHUNK_PASSWORD_EXTRACTOR -- requirements
Module: chunk_password_extractor

---
 rtl/chunk_password_extractor_pkg.sv | 47 ++++
 rtl/chunk_password_extractor_if.sv | 27 ++
 rtl/chunk_password_extractor_classifier.sv | 35 +++
 rtl/chunk_password_extractor.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/chunk_password_extractor_pkg.sv
// Shared constants, error codes, FSM states and word classes for the
// chunk password extractor.
package md5_chunk_pkg;

  localparam logic [7:0] PADDING   = 8'h80;
  localparam int         SIZE_LSB  = 448;
  localparam int         SIZE_MSB  = 479;
  localparam int         MAX_CHARS = 17;
  localparam int         MAX_BYTES = 34;
  localparam int         NUM_WORDS = 28;

  localparam logic [15:0] SKIP1_LO = 16'h003A;
  localparam logic [15:0] SKIP1_HI = 16'h0040;
  localparam logic [15:0] SKIP2_LO = 16'h005B;
  localparam logic [15:0] SKIP2_HI = 16'h0060;

  localparam logic [1:0] ERR_OK       = 2'd0;
  localparam logic [1:0] ERR_BAD_LEN  = 2'd1;
  localparam logic [1:0] ERR_BAD_PAD  = 2'd2;
  localparam logic [1:0] ERR_BAD_CHAR = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_EMIT,
    S_FINISH
  } state_t;

  typedef enum logic [2:0] {
    CHAR_OK,
    PAD_OK,
    ZERO_OK,
    FAULT_PAD,
    FAULT_CHAR
  } word_class_t;

  // Length field sanity: whole even byte count within 2..MAX_BYTES, upper size word clear.
  function automatic logic len_bad(input logic [511:0] blk);
    logic [31:0] size;
    logic [28:0] nbytes;
    size   = blk[SIZE_MSB:SIZE_LSB];
    nbytes = size[31:3];
    return (size[3:0] != 4'd0) || nbytes[0] || (nbytes < 29'd2) ||
           (nbytes > 29'(MAX_BYTES)) || (blk[511:480] != 32'd0);
  endfunction

endpackage

// File: rtl/chunk_password_extractor_if.sv
// Chunk input, character output stream and completion status of the extractor.
interface chunk_password_extractor_if;

  logic         chunk_valid;
  logic [511:0] chunk;
  logic         chunk_ready;
  logic [15:0]  min;
  logic [15:0]  max;
  logic         char_valid;
  logic [15:0]  char_data;
  logic         char_last;
  logic         char_ready;
  logic         done;
  logic [1:0]   err_code;
  logic [4:0]   pwd_len;

  modport slave (
    input  chunk_valid, chunk, min, max, char_ready,
    output chunk_ready, char_valid, char_data, char_last, done, err_code, pwd_len
  );

  modport master (
    output chunk_valid, chunk, min, max, char_ready,
    input  chunk_ready, char_valid, char_data, char_last, done, err_code, pwd_len
  );

endinterface

// File: rtl/chunk_password_extractor_classifier.sv
// Classifies one 16-bit word of the block as password character, padding
// marker or trailing zero, flagging the corresponding fault.
module chunk_word_classifier
  import md5_chunk_pkg::*;
(
  input  logic [15:0]  i_word,
  input  logic [4:0]   i_index,
  input  logic [5:0]   i_nbytes,
  input  logic [15:0]  i_min,
  input  logic [15:0]  i_max,
  output word_class_t  o_class
);

  logic [5:0] w_pos;
  logic       w_in_range;
  logic       w_in_skip;

  assign w_pos      = {i_index, 1'b0};
  assign w_in_range = (i_word >= i_min) && (i_word <= i_max);
  assign w_in_skip  = ((i_word >= SKIP1_LO) && (i_word <= SKIP1_HI)) ||
                      ((i_word >= SKIP2_LO) && (i_word <= SKIP2_HI));

  always_comb begin
    o_class = FAULT_CHAR;
    if (w_pos < i_nbytes) begin
      // Punctuation gaps are only legal when the range starts exactly there.
      o_class = (w_in_range && (!w_in_skip || (i_word == i_min))) ? CHAR_OK : FAULT_CHAR;
    end else if (w_pos == i_nbytes) begin
      o_class = (i_word == {8'h00, PADDING}) ? PAD_OK : FAULT_PAD;
    end else begin
      o_class = (i_word == 16'h0000) ? ZERO_OK : FAULT_PAD;
    end
  end

endmodule

// File: rtl/chunk_password_extractor.sv
// Validates an MD5 block carrying a UTF-16LE password and streams the
// recovered characters, ending each block with a one-cycle status pulse.
module chunk_password_extractor
  import md5_chunk_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  chunk_password_extractor_if.slave bus
);

  state_t       r_state;
  logic [447:0] r_chunk;
  logic [15:0]  r_min;
  logic [15:0]  r_max;
  logic [5:0]   r_nbytes;
  logic         r_bad_len;
  logic         r_bad_pad;
  logic         r_bad_char;
  logic [4:0]   r_idx;
  logic [4:0]   r_emit_idx;
  logic         r_chunk_ready;
  logic         r_char_valid;
  logic [15:0]  r_char_data;
  logic         r_char_last;
  logic         r_done;
  logic [1:0]   r_err_code;
  logic [4:0]   r_pwd_len;

  word_class_t  w_class;
  logic         w_any_pad;
  logic         w_any_char;
  logic [1:0]   w_err;
  logic [4:0]   w_next_idx;

  chunk_word_classifier u_classifier (
    .i_word   (r_chunk[{r_idx, 4'd0} +: 16]),
    .i_index  (r_idx),
    .i_nbytes (r_nbytes),
    .i_min    (r_min),
    .i_max    (r_max),
    .o_class  (w_class)
  );

  assign w_any_pad  = r_bad_pad  || (w_class == FAULT_PAD);
  assign w_any_char = r_bad_char || (w_class == FAULT_CHAR);
  assign w_err      = r_bad_len  ? ERR_BAD_LEN  :
                      w_any_pad  ? ERR_BAD_PAD  :
                      w_any_char ? ERR_BAD_CHAR : ERR_OK;
  assign w_next_idx = r_emit_idx + 5'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_chunk       <= '0;
      r_min         <= '0;
      r_max         <= '0;
      r_nbytes      <= '0;
      r_bad_len     <= 1'b0;
      r_bad_pad     <= 1'b0;
      r_bad_char    <= 1'b0;
      r_idx         <= '0;
      r_emit_idx    <= '0;
      r_chunk_ready <= 1'b1;
      r_char_valid  <= 1'b0;
      r_char_data   <= '0;
      r_char_last   <= 1'b0;
      r_done        <= 1'b0;
      r_err_code    <= ERR_OK;
      r_pwd_len     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.chunk_valid) begin
            r_chunk       <= bus.chunk[447:0];
            r_min         <= bus.min;
            r_max         <= bus.max;
            r_nbytes      <= bus.chunk[SIZE_LSB+8:SIZE_LSB+3];
            r_bad_len     <= len_bad(bus.chunk);
            r_bad_pad     <= 1'b0;
            r_bad_char    <= 1'b0;
            r_idx         <= '0;
            r_chunk_ready <= 1'b0;
            r_state       <= S_CHECK;
          end
        end

        S_CHECK: begin
          r_bad_pad  <= w_any_pad;
          r_bad_char <= w_any_char;
          // All 28 words are always scanned so the verdict latency is fixed.
          if (r_idx == 5'(NUM_WORDS - 1)) begin
            if (w_err == ERR_OK) begin
              r_char_valid <= 1'b1;
              r_char_data  <= r_chunk[15:0];
              r_char_last  <= (r_nbytes == 6'd2);
              r_emit_idx   <= '0;
              r_state      <= S_EMIT;
            end else begin
              r_done     <= 1'b1;
              r_err_code <= w_err;
              r_pwd_len  <= '0;
              r_state    <= S_FINISH;
            end
          end else begin
            r_idx <= r_idx + 5'd1;
          end
        end

        S_EMIT: begin
          if (r_char_valid && bus.char_ready) begin
            if (r_char_last) begin
              r_char_valid <= 1'b0;
              r_char_last  <= 1'b0;
              r_char_data  <= '0;
              r_done       <= 1'b1;
              r_err_code   <= ERR_OK;
              r_pwd_len    <= r_nbytes[5:1];
              r_state      <= S_FINISH;
            end else begin
              r_emit_idx  <= w_next_idx;
              r_char_data <= r_chunk[{w_next_idx, 4'd0} +: 16];
              r_char_last <= (w_next_idx == (r_nbytes[5:1] - 5'd1));
            end
          end
        end

        S_FINISH: begin
          r_done        <= 1'b0;
          r_err_code    <= ERR_OK;
          r_pwd_len     <= '0;
          r_chunk_ready <= 1'b1;
          r_state       <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.chunk_ready = r_chunk_ready;
  assign bus.char_valid  = r_char_valid;
  assign bus.char_data   = r_char_data;
  assign bus.char_last   = r_char_last;
  assign bus.done        = r_done;
  assign bus.err_code    = r_err_code;
  assign bus.pwd_len     = r_pwd_len;

endmodule
